// File: rtl/regfile_alu_seq_pkg.sv
// Shared types for the register-file ALU sequencer: operation codes, FSM states
// and datapath widths.
package regfile_alu_seq_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_alu_seq_alu32.sv
// Purely combinational 32-bit ALU used by the sequencer's EXEC stage.
module alu32
  import regfile_alu_seq_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] y
);

  // Shifts use only the low five bits of b so the amount stays within 0..31.
  always_comb begin
    y = '0;
    case (alu_op_t'(op))
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: y = a << b[4:0];
      OP_SRL: y = a >> b[4:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_seq.sv
// Four-state sequencer: accept a command, read two registers, execute on the ALU,
// write the result back, one cycle per state.
module regfile_alu_seq
  import regfile_alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [REG_AW-1:0] cmd_rd,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [XLEN-1:0]   wd3,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state_q, state_d;
  alu_op_t           op_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   opa_q, opb_q, result_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   alu_y;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  alu32 u_alu (
    .a  (opa_q),
    .b  (opb_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes to x0 are suppressed but still count as completed commands.
  always_comb begin
    cmd_ready = 1'b0;
    ra1       = '0;
    ra2       = '0;
    we3       = 1'b0;
    wa3       = '0;
    wd3       = '0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = reset;
      ST_READ: begin
        ra1 = rs1_q;
        ra2 = rs2_q;
      end
      ST_WB: begin
        done = 1'b1;
        if (rd_q != '0) begin
          we3 = 1'b1;
          wa3 = rd_q;
          wd3 = result_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_ADD;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= alu_op_t'(cmd_op);
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= cmd_rd;
      end
      if (state_q == ST_READ) begin
        opa_q <= rd1;
        opb_q <= rd2;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_y;
      end
      if (state_q == ST_WB) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign result   = result_q;
  assign op_count = count_q;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Bench for regfile_alu_seq: a simple register file, a transaction-level model
// checked every cycle, and directed commands with hand-computed results.
module tb_regfile_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        done;
  logic [31:0] result;
  logic [15:0] op_count;

  logic [31:0] rf [32];
  logic        plEn;
  logic [4:0]  plAddr;
  logic [31:0] plVal;

  int errCount = 0;
  int checkCount = 0;

  logic [31:0] modelRegs [32];
  bit          mActive = 1'b0;
  int          mDue = 0;
  int          cyc = 0;
  logic [4:0]  mRs1, mRs2, mRd;
  logic [31:0] mRes;
  logic [31:0] mLast = '0;
  logic [15:0] mCnt = '0;

  always #5 clk = ~clk;

  regfile_alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_rd    (cmd_rd),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .done      (done),
    .result    (result),
    .op_count  (op_count)
  );

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

  always @(posedge clk) begin
    if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
    if (plEn) rf[plAddr] <= plVal;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : modelRegs[idx];
  endfunction

  function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  // Model: an accepted command writes back exactly three cycles after the accept edge.
  always @(negedge clk) begin
    bit wbNow, readNow, expReady, wrNow;
    cyc++;
    if (!reset) begin
      mActive = 1'b0;
      mLast   = '0;
      mCnt    = '0;
      checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("rst_we3", {31'd0, we3}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_ra", {22'd0, ra1, ra2}, 32'd0);
      checkOutput("rst_wa3", {27'd0, wa3}, 32'd0);
      checkOutput("rst_wd3", wd3, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_op_count", {16'd0, op_count}, 32'd0);
    end else begin
      wbNow    = mActive && (cyc == mDue);
      readNow  = mActive && (cyc == mDue - 2);
      expReady = !mActive;
      wrNow    = wbNow && (mRd != 5'd0);
      if (wbNow) mLast = mRes;
      checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, expReady});
      checkOutput("done", {31'd0, done}, {31'd0, wbNow});
      checkOutput("we3", {31'd0, we3}, {31'd0, wrNow});
      checkOutput("wa3", {27'd0, wa3}, wrNow ? {27'd0, mRd} : 32'd0);
      checkOutput("wd3", wd3, wrNow ? mRes : 32'd0);
      checkOutput("ra1", {27'd0, ra1}, readNow ? {27'd0, mRs1} : 32'd0);
      checkOutput("ra2", {27'd0, ra2}, readNow ? {27'd0, mRs2} : 32'd0);
      checkOutput("result", result, mLast);
      checkOutput("op_count", {16'd0, op_count}, {16'd0, mCnt});
      if (wbNow) begin
        if (mRd != 5'd0) modelRegs[mRd] = mRes;
        mCnt    = mCnt + 16'd1;
        mActive = 1'b0;
      end
      if (plEn) modelRegs[plAddr] = plVal;
      if (expReady && cmd_valid) begin
        mActive = 1'b1;
        mDue    = cyc + 3;
        mRs1    = cmd_rs1;
        mRs2    = cmd_rs2;
        mRd     = cmd_rd;
        mRes    = aluModel(cmd_op, modelRead(cmd_rs1), modelRead(cmd_rs2));
      end
    end
  end

  task automatic preload(input logic [4:0] addr, input logic [31:0] val);
    plAddr = addr;
    plVal  = val;
    plEn   = 1'b1;
    @(posedge clk);
    #1 plEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
    bit seen;
    cmd_op    = op;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
    end
    if (!seen) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL accept_timeout: cmd_ready got 0 expected 1 within 10 cycles");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic runCmd(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
    applyStimulus(op, rs1, rs2, rd);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_rd    = '0;
    plEn      = 1'b0;
    plAddr    = '0;
    plVal     = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    preload(5'd5, 32'hA5A5A5A5);
    preload(5'd10, 32'h5A5A5A5A);
    preload(5'd1, 32'h0);
    preload(5'd2, 32'h1);
    preload(5'd7, 32'h1);
    preload(5'd8, 32'h3F);
    preload(5'd20, 32'h0);

    runCmd(3'd0, 5'd5, 5'd10, 5'd3);
    checkOutput("lit_add_x3", rf[3], 32'hFFFFFFFF);
    checkOutput("lit_add_count", {16'd0, op_count}, 32'd1);
    runCmd(3'd1, 5'd1, 5'd2, 5'd4);
    checkOutput("lit_sub_x4", rf[4], 32'hFFFFFFFF);
    runCmd(3'd5, 5'd1, 5'd2, 5'd6);
    checkOutput("lit_slt_x6", rf[6], 32'd1);
    preload(5'd1, 32'h80000000);
    runCmd(3'd5, 5'd1, 5'd2, 5'd9);
    checkOutput("lit_slt_neg_x9", rf[9], 32'd1);
    runCmd(3'd6, 5'd7, 5'd8, 5'd14);
    checkOutput("lit_sll_x14", rf[14], 32'h80000000);
    preload(5'd7, 32'h80000000);
    preload(5'd8, 32'd31);
    runCmd(3'd7, 5'd7, 5'd8, 5'd15);
    checkOutput("lit_srl_x15", rf[15], 32'h00000001);
    runCmd(3'd2, 5'd5, 5'd10, 5'd16);
    checkOutput("lit_and_x16", rf[16], 32'h0);
    runCmd(3'd3, 5'd5, 5'd10, 5'd17);
    checkOutput("lit_or_x17", rf[17], 32'hFFFFFFFF);
    runCmd(3'd4, 5'd5, 5'd2, 5'd18);
    checkOutput("lit_xor_x18", rf[18], 32'hA5A5A5A4);

    runCmd(3'd0, 5'd5, 5'd10, 5'd0);
    checkOutput("lit_x0_result", result, 32'hFFFFFFFF);
    checkOutput("lit_x0_count", {16'd0, op_count}, 32'd10);

    runCmd(3'd0, 5'd5, 5'd5, 5'd5);
    checkOutput("lit_self_x5", rf[5], 32'h4B4B4B4A);

    // Valid stays high across both commands; the second must see the first's write.
    cmd_op    = 3'd0;
    cmd_rs1   = 5'd10;
    cmd_rs2   = 5'd10;
    cmd_rd    = 5'd12;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_rs1 = 5'd12;
    cmd_rs2 = 5'd12;
    cmd_rd  = 5'd13;
    repeat (4) @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("lit_b2b_x12", rf[12], 32'hB4B4B4B4);
    checkOutput("lit_b2b_x13", rf[13], 32'h69696968);
    checkOutput("lit_model_x13", modelRegs[13], 32'h69696968);

    applyStimulus(3'd0, 5'd5, 5'd10, 5'd20);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("lit_abort_x20", rf[20], 32'h0);
    checkOutput("lit_abort_count", {16'd0, op_count}, 32'd0);

    runCmd(3'd0, 5'd7, 5'd7, 5'd21);
    checkOutput("lit_post_rst_x21", rf[21], 32'h0);
    checkOutput("lit_post_rst_count", {16'd0, op_count}, 32'd1);
    runCmd(3'd1, 5'd2, 5'd7, 5'd22);
    checkOutput("lit_post_rst_x22", rf[22], 32'h80000001);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_alu_seq.md
REGFILE_ALU_SEQ -- requirements
Module: regfile_alu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 clk  in  1  rising-edge clock shared with regfile.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_op  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL.
REQ-007 cmd_rs1, cmd_rs2, cmd_rd  in  5 each  source/destination register indices.
REQ-008 ra1, ra2  out  5 each  regfile read addresses.
REQ-009 rd1, rd2  in  32 each  regfile read data (combinational read).
REQ-010 we3  out  1  regfile write enable.
REQ-011 wa3  out  5  regfile write address.
REQ-012 wd3  out  32  regfile write data.
REQ-013 done  out  1  one-cycle pulse at write-back of each command.
REQ-014 result  out  32  last computed result, held until the next write-back.
REQ-015 op_count  out  16  count of completed commands.

Function
REQ-016 FSM states SHALL be IDLE, READ, EXEC, WB, visited in that order, one cycle each.
REQ-017 A command SHALL be accepted on a rising edge with cmd_valid=1, cmd_ready=1; op, rs1, rs2, rd are latched; IDLE->READ.
REQ-018 cmd_ready SHALL be 1 only in IDLE with reset deasserted; cmd_valid outside IDLE is ignored, not queued.
REQ-019 In READ, ra1/ra2 SHALL be driven with latched rs1/rs2; rd1/rd2 are captured into operand registers at the end of READ.
REQ-020 In EXEC, the operation SHALL be applied to the captured operands and the 32-bit result registered; ADD/SUB wrap modulo 2^32; SLT yields 1 or 0; SLL/SRL shift by operand B bits [4:0]; SRL is logical.
REQ-021 In WB, we3=1, wa3=rd, wd3=result and done=1 SHALL hold for exactly one cycle, then the FSM returns to IDLE.
REQ-022 Latency SHALL be fixed: a command accepted on edge N produces we3/done high during the cycle after edge N+2, and cmd_ready returns high after edge N+3.
REQ-023 When rd=0, we3 SHALL stay 0 in WB, while done still pulses, result updates and op_count increments.
REQ-024 we3 SHALL be 0 in every state except WB; wa3/wd3 are don't-care when we3=0 but SHALL be driven as 0.
REQ-025 op_count SHALL increment by 1 on every WB cycle, wrapping from 16'hFFFF to 0.
REQ-026 rs1=rs2 and rs==rd SHALL be legal; operands are those read in READ, before the WB write.
REQ-027 Back-to-back commands SHALL see the previous command's write; the IDLE gap guarantees this without forwarding.

Reset
REQ-028 reset=0 SHALL asynchronously force: state IDLE; cmd_ready, we3, done 0; ra1, ra2, wa3 0; wd3, result 0; op_count 0; latched fields and operands 0.
REQ-029 Reset asserted mid-command SHALL abort that command with no write issued; the FSM restarts in IDLE.
REQ-030 cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-031 A shared package SHALL define the alu_op_t enum (3-bit, values in REQ-006) and the state_t enum.
REQ-032 A combinational sub-module alu32 (a, b, op -> y) SHALL hold the arithmetic; regfile_alu_seq keeps the FSM, operand and result registers, and the counter.
REQ-033 The top-level bench SHALL instantiate regfile_alu_seq with the existing regfile, wired by port name.

Verification
REQ-034 Preload x5=A5A5A5A5, x10=5A5A5A5A; ADD rd=3, rs1=5, rs2=10 -> x3=FFFFFFFF, done 3 cycles after accept, op_count=1.
REQ-035 SUB rd=4 with x1=0, x2=1 -> x4=FFFFFFFF; SLT rd=6 with x1=0, x2=1 -> x6=1; SLT with x1=80000000, x2=1 -> 1.
REQ-036 SLL with x7=1, x8=0000003F (shift amount 31) -> 80000000; SRL with x7=80000000, x8=31 -> 00000001.
REQ-037 ADD with rd=0 -> we3 never asserted, done pulses, x0 reads 0, result updated.
REQ-038 cmd_valid held high for 2 commands -> second accepted only after WB; the second reads the first's rd value (x3 then x3+x3).
REQ-039 reset=0 during EXEC -> no we3, all outputs 0, op_count 0, and a new command after release completes normally.
